// File: rtl/msf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msf_pkg : shared state encoding, sync pattern and frame field layout for   |
// |           the MSF frame sequencer.                                          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package msf_pkg;

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } msf_state_t;

   // A-bit sequence of seconds 52..59, oldest bit in the MSB
   localparam logic [7:0] SYNC_PATTERN = 8'b0111_1110;

   localparam logic [5:0] SEC_FRAME_FIRST = 6'd17;
   localparam logic [5:0] SEC_FRAME_LAST  = 6'd51;
   localparam logic [5:0] SEC_B_FIRST     = 6'd54;
   localparam logic [5:0] SEC_B_LAST      = 6'd57;
   localparam logic [5:0] SEC_LAST        = 6'd59;

   localparam int FRAME_W = 35;
   localparam int B_W     = 4;

   localparam logic [5:0] YEAR_SEC   = 6'd17;
   localparam logic [5:0] MONTH_SEC  = 6'd25;
   localparam logic [5:0] DAY_SEC    = 6'd30;
   localparam logic [5:0] DOW_SEC    = 6'd36;
   localparam logic [5:0] HOUR_SEC   = 6'd39;
   localparam logic [5:0] MINUTE_SEC = 6'd45;

   localparam int YEAR_W       = 8;
   localparam int MONTH_W      = 5;
   localparam int DAY_W        = 6;
   localparam int DOW_W        = 3;
   localparam int HOUR_W       = 6;
   localparam int MINUTE_W     = 7;
   localparam int MINUTE_OUT_W = 6;

   // Bits are shifted in MSB first, so second 51 ends up in frame bit 0
   function automatic int field_lsb(input logic [5:0] start_sec, input int width);
      return int'(SEC_FRAME_LAST) - int'(start_sec) - width + 1;
   endfunction

   localparam int YEAR_LSB   = field_lsb(YEAR_SEC, YEAR_W);
   localparam int MONTH_LSB  = field_lsb(MONTH_SEC, MONTH_W);
   localparam int DAY_LSB    = field_lsb(DAY_SEC, DAY_W);
   localparam int DOW_LSB    = field_lsb(DOW_SEC, DOW_W);
   localparam int HOUR_LSB   = field_lsb(HOUR_SEC, HOUR_W);
   localparam int MINUTE_LSB = field_lsb(MINUTE_SEC, MINUTE_W);

endpackage
`default_nettype wire

// File: rtl/msf_parity_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msf_parity_check : odd-parity check of the four MSF parity groups.         |
// | Built only when MSF_PARITY_EN is defined.                                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`ifdef MSF_PARITY_EN
module msf_parity_check
   import msf_pkg::*;
(
   input  logic [FRAME_W-1:0] frame_i,
   input  logic [B_W-1:0]     par_b_i,
   output logic               parity_ok_o
);

   logic [B_W-1:0] w_group_ok;

   // par_b_i holds 54B in its MSB down to 57B in its LSB
   assign w_group_ok[3] = ^{frame_i[YEAR_LSB +: YEAR_W], par_b_i[3]};
   assign w_group_ok[2] = ^{frame_i[DAY_LSB +: (MONTH_W + DAY_W)], par_b_i[2]};
   assign w_group_ok[1] = ^{frame_i[DOW_LSB +: DOW_W], par_b_i[1]};
   assign w_group_ok[0] = ^{frame_i[MINUTE_LSB +: (HOUR_W + MINUTE_W)], par_b_i[0]};

   assign parity_ok_o = &w_group_ok;

endmodule
`endif
`default_nettype wire

// File: rtl/msf_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msf_frame_sequencer : MSF minute-frame alignment and BCD field capture.    |
// | Optional B-bit parity checking with MSF_PARITY_EN.                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module msf_frame_sequencer
   import msf_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       bit_a_i,
   input  logic       bit_b_i,
   input  logic       valid_i,
   output logic       locked_o,
   output logic [5:0] second_o,
   output logic [7:0] year_o,
   output logic [4:0] month_o,
   output logic [5:0] day_o,
   output logic [2:0] dow_o,
   output logic [5:0] hour_o,
   output logic [5:0] minute_o,
   output logic       time_valid_o,
   output logic       frame_stb_o,
   output logic       error_o
);

   localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(TIMEOUT_CYCLES);
   localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

   msf_state_t         r_state;
   logic [7:0]         r_hist;
   logic [FRAME_W-1:0] r_frame;
   logic [5:0]         r_second;
   logic [c_to_w-1:0]  r_to_cnt;

   logic [5:0] w_next_sec;
   logic [7:0] w_hist_next;
   logic       w_sync_ok;
   logic       w_to_expire;
   logic       w_in_frame;
   logic       w_parity_ok;

   assign w_next_sec  = (r_second == SEC_LAST) ? 6'd0 : r_second + 6'd1;
   assign w_hist_next = {r_hist[6:0], bit_a_i};
   assign w_sync_ok   = (w_hist_next == SYNC_PATTERN);
   assign w_to_expire = (r_to_cnt == c_to_last);
   assign w_in_frame  = (w_next_sec >= SEC_FRAME_FIRST) && (w_next_sec <= SEC_FRAME_LAST);

   assign locked_o = (r_state == ST_LOCKED);
   assign second_o = r_second;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_HUNT;
         r_hist       <= '0;
         r_frame      <= '0;
         r_second     <= '0;
         r_to_cnt     <= '0;
         year_o       <= '0;
         month_o      <= '0;
         day_o        <= '0;
         dow_o        <= '0;
         hour_o       <= '0;
         minute_o     <= '0;
         time_valid_o <= 1'b0;
         frame_stb_o  <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         frame_stb_o <= 1'b0;
         error_o     <= 1'b0;

         // A strobe in the expiry cycle takes priority over the timeout
         if (valid_i) begin
            r_to_cnt <= '0;
            r_hist   <= w_hist_next;
            case (r_state)
               ST_HUNT: begin
                  if (w_sync_ok) begin
                     r_state  <= ST_LOCKED;
                     r_second <= SEC_LAST;
                  end
               end
               ST_LOCKED: begin
                  r_second <= w_next_sec;
                  if (w_in_frame) begin
                     r_frame <= {r_frame[FRAME_W-2:0], bit_a_i};
                  end
                  if (w_next_sec == SEC_LAST) begin
                     if (!w_sync_ok) begin
                        error_o  <= 1'b1;
                        r_state  <= ST_HUNT;
                        r_second <= '0;
                     end else if (!w_parity_ok) begin
                        error_o <= 1'b1;
                     end else begin
                        year_o       <= r_frame[YEAR_LSB +: YEAR_W];
                        month_o      <= r_frame[MONTH_LSB +: MONTH_W];
                        day_o        <= r_frame[DAY_LSB +: DAY_W];
                        dow_o        <= r_frame[DOW_LSB +: DOW_W];
                        hour_o       <= r_frame[HOUR_LSB +: HOUR_W];
                        // The 7-bit minute field's top (tens = 40) bit does not fit the port
                        minute_o     <= r_frame[MINUTE_LSB +: MINUTE_OUT_W];
                        time_valid_o <= 1'b1;
                        frame_stb_o  <= 1'b1;
                     end
                  end
               end
            endcase
         end else if (r_to_cnt != c_to_max) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
            if (w_to_expire && (r_state == ST_LOCKED)) begin
               error_o  <= 1'b1;
               r_state  <= ST_HUNT;
               r_second <= '0;
               r_hist   <= '0;
            end
         end
      end
   end

`ifdef MSF_PARITY_EN
   logic [B_W-1:0] r_par_b;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_par_b <= '0;
      end else if (valid_i && (r_state == ST_LOCKED) &&
                   (w_next_sec >= SEC_B_FIRST) && (w_next_sec <= SEC_B_LAST)) begin
         r_par_b <= {r_par_b[B_W-2:0], bit_b_i};
      end
   end

   msf_parity_check u_parity_check (
      .frame_i     (r_frame),
      .par_b_i     (r_par_b),
      .parity_ok_o (w_parity_ok)
   );
`else
   logic w_unused_bits;

   assign w_parity_ok   = 1'b1;
   assign w_unused_bits = ^{bit_b_i, r_frame[MINUTE_LSB + MINUTE_W - 1],
                            SEC_B_FIRST, SEC_B_LAST, B_W[0]};
`endif

endmodule
`default_nettype wire

// File: doc/msf_frame_sequencer.md
MSF_FRAME_SEQUENCER -- requirements
Module: msf_frame_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, clocks without valid_i before lock is dropped.
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports bit_a_i / bit_b_i  input  1 each  decoded A/B bits of current second, qualified by valid_i.
REQ-005 SHALL have port valid_i  input  1  one-cycle strobe, once per received second.
REQ-006 SHALL have port locked_o  output  1  frame alignment held.
REQ-007 SHALL have port second_o  output  6  current second index 0..59, meaningful only when locked.
REQ-008 SHALL have ports year_o 8, month_o 5, day_o 6, dow_o 3, hour_o 6, minute_o 6  outputs  BCD fields of last accepted frame.
REQ-009 SHALL have port time_valid_o  output  1  level; fields hold a checked frame.
REQ-010 SHALL have port frame_stb_o  output  1  one-cycle pulse when fields update.
REQ-011 SHALL have port error_o  output  1  one-cycle pulse on sync loss, parity fail or timeout.

Function
REQ-012 SHALL implement states HUNT and LOCKED.
REQ-013 HUNT: every valid_i shifts bit_a_i into an 8-bit history; history equal to 01111110 (oldest first) SHALL enter LOCKED with second counter 59.
REQ-014 LOCKED: each valid_i SHALL advance second counter 59->0->1..59, wrapping at 59.
REQ-015 A bits at seconds 17..51 SHALL be shifted into a 35-bit frame register; B bits at seconds 54..57 SHALL be captured.
REQ-016 At second 59 the A history SHALL be compared to 01111110; match: fields update and frame_stb_o pulses the following cycle; mismatch: error_o pulses, state returns HUNT, fields and time_valid_o unchanged.
REQ-017 Field mapping (second numbers): year 17-24, month 25-29, day 30-35, dow 36-38, hour 39-44, minute 45-51, MSB first.
REQ-018 time_valid_o SHALL set with the first frame_stb_o and stay set until reset.
REQ-019 Timeout counter SHALL clear on every valid_i; reaching TIMEOUT_CYCLES in LOCKED SHALL pulse error_o once and return HUNT with history cleared; in HUNT it saturates silently.
REQ-020 valid_i in the same cycle as timeout expiry SHALL win (counter clears, no error).
REQ-021 Leap-second (61 s) minutes are unsupported; the resulting mismatch SHALL resync per REQ-016.
REQ-022 second_o SHALL read 0 while in HUNT; locked_o SHALL be high exactly in LOCKED.

Reset
REQ-023 rst_i SHALL force HUNT, history/frame/counters 0, all outputs 0, on the next edge, including mid-frame.

Configuration
REQ-024 With MSF_PARITY_EN defined, odd parity SHALL be checked at second 59: 54B over 17-24, 55B over 25-35, 56B over 36-38, 57B over 39-51; any failure pulses error_o, suppresses update, keeps LOCKED.
REQ-025 Without MSF_PARITY_EN, bit_b_i SHALL be ignored and no parity logic built.

Structure
REQ-026 msf_pkg SHALL hold the state enum, sync pattern constant and field start/width constants.
REQ-027 Parity evaluation SHALL be a sub-module msf_parity_check, instantiated only under MSF_PARITY_EN.

Verification
REQ-028 Reset then two clean frames for 2023-06-15 Thu 12:34 -> locked_o after first 52..59 pattern, frame_stb_o once at end of second frame, year_o=0x23 month_o=0x06 day_o=0x15 dow_o=4 hour_o=0x12 minute_o=0x34.
REQ-029 Locked, second-57 A bit flipped -> error_o one pulse, locked_o=0, fields unchanged, relock on next pattern.
REQ-030 Locked, valid_i stopped -> error_o exactly TIMEOUT_CYCLES clocks after last valid_i, locked_o=0.
REQ-031 MSF_PARITY_EN, bad 57B -> error_o pulse, no frame_stb_o, locked_o stays 1; good next frame updates.
REQ-032 rst_i at second 30 -> all outputs 0 next cycle, HUNT; subsequent frame decodes correctly.
REQ-033 Random A bits containing no 01111110 for 200 seconds -> locked_o never asserts, no error_o.
